// File: rtl/rx_cgmii_decap.sv
// rx_cgmii_decap: CGMII (32-lane, 256-bit) receive decapsulation.
//   Finds the start character (FB, lane 0), drops the 7 preamble/SFD lanes,
//   re-packs the frame so byte 0 sits at rx_data[7:0], and marks the
//   first and last beats. A terminate (FD) ends the frame. The frame is
//   checked for stray control characters, bad idle fill after the
//   terminate, a restart inside a frame, and a length outside
//   MIN_LEN..MAX_LEN. Packet, byte and error statistics are kept.
// Ports:
//   clk156, rst          clock, synchronous active-high reset
//   rxd, rxc, rxd_vld    CGMII data/control lanes and beat strobe
//   fmac_rx_clr_en       synchronous clear of the statistics counters
//   rx_data, rx_be       realigned beat and its valid byte count (1..32)
//   rx_dvld, rx_sop,
//   rx_eop, rx_err       beat valid, first beat, last beat, frame error
//   rx_bytes             frame byte count, valid with rx_eop
//   FMAC_RX_*_CNT        packet / byte / error statistics
module rx_cgmii_decap #(
    parameter logic [15:0] MAX_LEN = 16'd9600,
    parameter logic [15:0] MIN_LEN = 16'd64
) (
    input  logic         clk156,
    input  logic         rst,
    input  logic [255:0] rxd,
    input  logic [31:0]  rxc,
    input  logic         rxd_vld,
    input  logic         fmac_rx_clr_en,
    output logic [255:0] rx_data,
    output logic         rx_dvld,
    output logic         rx_sop,
    output logic         rx_eop,
    output logic         rx_err,
    output logic [5:0]   rx_be,
    output logic [15:0]  rx_bytes,
    output logic [31:0]  FMAC_RX_PKT_CNT,
    output logic [31:0]  FMAC_RX_BYTE_CNT,
    output logic [31:0]  FMAC_RX_ERR_CNT
);

    localparam logic [7:0] START_CH = 8'hFB;
    localparam logic [7:0] TERM_CH  = 8'hFD;
    localparam logic [7:0] IDLE_CH  = 8'h07;

    typedef enum logic [1:0] {IDLE, DATA, FLUSH} state_t;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [5:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {11'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic len_bad(input logic [15:0] n);
        return (n < MIN_LEN) || (n > MAX_LEN);
    endfunction

    // Zero the bytes beyond the valid count so stale lanes never leak out.
    function automatic logic [255:0] keep_bytes(input logic [255:0] d, input logic [5:0] be);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (6'(i) < be) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    state_t         state_q, state_d;
    logic [191:0]   held_q, held_d;       // 24 bytes carried into the next beat
    logic [15:0]    acc_q, acc_d;         // bytes already emitted for this frame
    logic           ferr_q, ferr_d;       // error seen earlier in this frame
    logic           first_q, first_d;     // next emitted beat is the sop beat
    logic [5:0]     flush_be_q, flush_be_d;
    logic [255:0]   rx_data_q, rx_data_d;
    logic [5:0]     rx_be_q, rx_be_d;
    logic [15:0]    rx_bytes_q, rx_bytes_d;
    logic           rx_dvld_q, rx_dvld_d, rx_sop_q, rx_sop_d;
    logic           rx_eop_q, rx_eop_d, rx_err_q, rx_err_d;
    logic [31:0]    pkt_q, pkt_d, byte_q, byte_d, errc_q, errc_d;

    logic           is_start, term_found, pre_ctl, post_bad, start_ok, drop;
    logic [4:0]     term_lane;

    assign is_start = rxc[0] && (rxd[7:0] == START_CH);

    // Lowest terminate lane, plus control lanes before it and bad fill after it.
    always_comb begin
        term_found = 1'b0;
        term_lane  = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (rxc[i] && (rxd[8*i +: 8] == TERM_CH)) begin
                term_found = 1'b1;
                term_lane  = 5'(i);
            end
        end
        pre_ctl  = 1'b0;
        post_bad = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (!term_found || (5'(i) < term_lane)) begin
                pre_ctl = pre_ctl | rxc[i];
            end else if ((5'(i) > term_lane) && !(rxc[i] && (rxd[8*i +: 8] == IDLE_CH))) begin
                post_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        acc_d      = acc_q;
        ferr_d     = ferr_q;
        first_d    = first_q;
        flush_be_d = flush_be_q;
        rx_data_d  = rx_data_q;
        rx_be_d    = rx_be_q;
        rx_bytes_d = rx_bytes_q;
        rx_dvld_d  = 1'b0;
        rx_sop_d   = 1'b0;
        rx_eop_d   = 1'b0;
        rx_err_d   = 1'b0;
        start_ok   = 1'b0;
        case (state_q)
            IDLE: start_ok = rxd_vld && is_start;
            DATA: begin
                if (rxd_vld) begin
                    if (is_start) begin
                        // Restart inside a frame: close it with what is held.
                        rx_dvld_d  = 1'b1;
                        rx_sop_d   = first_q;
                        rx_eop_d   = 1'b1;
                        rx_err_d   = 1'b1;
                        rx_be_d    = 6'd24;
                        rx_data_d  = {64'd0, held_q};
                        rx_bytes_d = sat_add(acc_q, 6'd24);
                        state_d    = IDLE;
                        start_ok   = 1'b1;
                    end else if (term_found && (term_lane <= 5'd8)) begin
                        rx_dvld_d  = 1'b1;
                        rx_sop_d   = first_q;
                        rx_eop_d   = 1'b1;
                        rx_be_d    = 6'd24 + 6'(term_lane);
                        rx_data_d  = keep_bytes({rxd[63:0], held_q}, 6'd24 + 6'(term_lane));
                        rx_bytes_d = sat_add(acc_q, 6'd24 + 6'(term_lane));
                        rx_err_d   = ferr_q | pre_ctl | post_bad
                                   | len_bad(sat_add(acc_q, 6'd24 + 6'(term_lane)));
                        state_d    = IDLE;
                    end else begin
                        // Full beat; a late terminate leaves a tail for FLUSH.
                        rx_dvld_d = 1'b1;
                        rx_sop_d  = first_q;
                        rx_be_d   = 6'd32;
                        rx_data_d = {rxd[63:0], held_q};
                        held_d    = rxd[255:64];
                        acc_d     = sat_add(acc_q, 6'd32);
                        ferr_d    = ferr_q | pre_ctl | post_bad;
                        first_d   = 1'b0;
                        if (term_found) begin
                            flush_be_d = 6'(term_lane) - 6'd8;
                            state_d    = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                // Tail leaves regardless of rxd_vld; held_q may be reloaded by a new start.
                rx_dvld_d  = 1'b1;
                rx_eop_d   = 1'b1;
                rx_be_d    = flush_be_q;
                rx_data_d  = keep_bytes({64'd0, held_q}, flush_be_q);
                rx_bytes_d = sat_add(acc_q, flush_be_q);
                rx_err_d   = ferr_q | len_bad(sat_add(acc_q, flush_be_q));
                state_d    = IDLE;
                start_ok   = rxd_vld && is_start;
            end
            default: state_d = IDLE;
        endcase

        // A start beat that also carries a terminate is dropped unseen.
        drop = start_ok && term_found;
        if (start_ok && !term_found) begin
            held_d  = rxd[255:64];
            acc_d   = 16'd0;
            ferr_d  = |rxc[31:1];
            first_d = 1'b1;
            state_d = DATA;
        end

        pkt_d  = pkt_q + 32'(rx_eop_d);
        byte_d = byte_q + (rx_eop_d ? {16'd0, rx_bytes_d} : 32'd0);
        errc_d = errc_q + 32'(rx_eop_d && rx_err_d) + 32'(drop);
        if (fmac_rx_clr_en) begin
            pkt_d  = 32'd0;
            byte_d = 32'd0;
            errc_d = 32'd0;
        end
    end

    always_ff @(posedge clk156) begin
        if (rst) begin
            state_q    <= IDLE;
            held_q     <= '0;
            acc_q      <= '0;
            ferr_q     <= 1'b0;
            first_q    <= 1'b0;
            flush_be_q <= '0;
            rx_data_q  <= '0;
            rx_be_q    <= '0;
            rx_bytes_q <= '0;
            rx_dvld_q  <= 1'b0;
            rx_sop_q   <= 1'b0;
            rx_eop_q   <= 1'b0;
            rx_err_q   <= 1'b0;
            pkt_q      <= '0;
            byte_q     <= '0;
            errc_q     <= '0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            acc_q      <= acc_d;
            ferr_q     <= ferr_d;
            first_q    <= first_d;
            flush_be_q <= flush_be_d;
            rx_data_q  <= rx_data_d;
            rx_be_q    <= rx_be_d;
            rx_bytes_q <= rx_bytes_d;
            rx_dvld_q  <= rx_dvld_d;
            rx_sop_q   <= rx_sop_d;
            rx_eop_q   <= rx_eop_d;
            rx_err_q   <= rx_err_d;
            pkt_q      <= pkt_d;
            byte_q     <= byte_d;
            errc_q     <= errc_d;
        end
    end

    assign rx_data          = rx_data_q;
    assign rx_be            = rx_be_q;
    assign rx_bytes         = rx_bytes_q;
    assign rx_dvld          = rx_dvld_q;
    assign rx_sop           = rx_sop_q;
    assign rx_eop           = rx_eop_q;
    assign rx_err           = rx_err_q;
    assign FMAC_RX_PKT_CNT  = pkt_q;
    assign FMAC_RX_BYTE_CNT = byte_q;
    assign FMAC_RX_ERR_CNT  = errc_q;

endmodule
